// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_pkg;

  // Edge select encoding as it appears on the mode input.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  // Widest channel vector the block supports, and enough bits to count it.
  localparam int MAX_WIDTH = 32;
  localparam int POP_W     = 6;

  // Number of set bits in a channel vector (zero-extended to MAX_WIDTH).
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  // True when an accepted edge towards new_lvl is one the mode asks to report.
  function automatic logic edge_selected(input edge_mode_t m, input logic new_lvl);
    logic sel;
    unique case (m)
      EDGE_RISE: sel = new_lvl;
      EDGE_FALL: sel = ~new_lvl;
      EDGE_BOTH: sel = 1'b1;
      default:   sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel of the edge detector: glitch filter on a single input bit and
// a registered one-cycle pulse when a new level is accepted.
// A new level must be seen on FILT+1 consecutive samples before lvl follows it;
// any sample back at the current lvl restarts the wait.
module edge_chan
  import edge_pkg::*;
#(
  parameter int FILT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  edge_mode_t mode,
  output logic       dout
);

  // Stability counter wide enough to reach FILT, never narrower than one bit.
  localparam int            CW       = (FILT == 0) ? 1 : $clog2(FILT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT);

  logic          lvl;
  logic [CW-1:0] cnt;

  // Filter the input level and pulse dout on the edge that accepts a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl  <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      dout <= 1'b0;
      if (din == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Level has held long enough: accept it; mode only gates the pulse.
        lvl  <= din;
        cnt  <= '0;
        dout <= edge_selected(mode, din);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_detector_mc.sv
// Multi-channel filtered edge detector. Each bit of din is filtered by its own
// edge_chan; this level collects the pulses into a sticky flag vector, an
// any-edge indicator and a saturating count of all pulses seen.
module edge_detector_mc
  import edge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FILT  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] sticky,
  output logic             any_edge,
  output logic [CNT_W-1:0] event_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  edge_mode_t           mode_e;
  logic [MAX_WIDTH-1:0] dout_ext;
  logic [POP_W-1:0]     pulses;
  logic [CNT_W:0]       cnt_sum;

  assign mode_e = edge_mode_t'(mode);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    edge_chan #(
      .FILT (FILT)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .din   (din[g]),
      .mode  (mode_e),
      .dout  (dout[g])
    );
  end

  // Same-cycle OR of the pulses, no register in the path.
  assign any_edge = |dout;

  // Pulse count for this cycle and the one-bit-wider sum used to detect saturation.
  always_comb begin
    dout_ext               = '0;
    dout_ext[WIDTH-1:0]    = dout;
    pulses                 = popcount(dout_ext);
    cnt_sum                = {1'b0, event_cnt} + (CNT_W + 1)'(pulses);
  end

  // Sticky flags and event counter; clr reloads from the current pulses so a
  // pulse landing on the clr cycle is still recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky    <= '0;
      event_cnt <= '0;
    end else if (clr) begin
      sticky    <= dout;
      event_cnt <= CNT_W'(pulses);
    end else begin
      sticky    <= sticky | dout;
      event_cnt <= cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_edge_detector_mc.sv
// Bench for edge_detector_mc: two instances (FILT=0/CNT_W=6 and FILT=3/CNT_W=16)
// share one stimulus stream; a run-length model predicts every cycle's outputs.
module tb_edge_detector_mc;

  localparam int         W    = 8;
  localparam logic [1:0] RISE = 2'b00;
  localparam logic [1:0] FALL = 2'b01;
  localparam logic [1:0] BOTH = 2'b10;
  localparam logic [1:0] OFF  = 2'b11;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [W-1:0] din   = '0;
  logic [1:0]   mode  = RISE;
  logic         clr   = 1'b0;

  logic [W-1:0] dout0, sticky0, dout3, sticky3;
  logic         any0, any3;
  logic [5:0]   ev0;
  logic [15:0]  ev3;

  edge_detector_mc #(.WIDTH(W), .FILT(0), .CNT_W(6)) u0 (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr),
    .dout(dout0), .sticky(sticky0), .any_edge(any0), .event_cnt(ev0)
  );

  edge_detector_mc #(.WIDTH(W), .FILT(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr),
    .dout(dout3), .sticky(sticky3), .any_edge(any3), .event_cnt(ev3)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  // Per channel: accepted level and how many samples in a row din has disagreed
  // with it. A disagreement lasting filt+1 samples becomes an accepted edge.
  logic         m_lvl   [2][W];
  int           m_run   [2][W];
  logic [W-1:0] m_dout  [2];
  logic [W-1:0] m_sticky[2];
  int           m_cnt   [2];

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q3[$];

  task automatic model_step(input int k, input int filt, input int cmax);
    logic [W-1:0] p;
    p = '0;
    if (reset) begin
      for (int i = 0; i < W; i++) begin
        m_lvl[k][i] = 1'b0;
        m_run[k][i] = 0;
      end
      m_dout[k]   = '0;
      m_sticky[k] = '0;
      m_cnt[k]    = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (din[i] == m_lvl[k][i]) begin
          m_run[k][i] = 0;
        end else begin
          m_run[k][i] = m_run[k][i] + 1;
          if (m_run[k][i] == filt + 1) begin
            m_lvl[k][i] = din[i];
            m_run[k][i] = 0;
            if (mode == BOTH || (mode == RISE && din[i]) || (mode == FALL && !din[i]))
              p[i] = 1'b1;
          end
        end
      end
      // Counters see the pulses that were visible during the cycle just ended.
      if (clr) begin
        m_sticky[k] = m_dout[k];
        m_cnt[k]    = $countones(m_dout[k]);
      end else begin
        m_sticky[k] = m_sticky[k] | m_dout[k];
        m_cnt[k]    = m_cnt[k] + $countones(m_dout[k]);
        if (m_cnt[k] > cmax) m_cnt[k] = cmax;
      end
      m_dout[k] = p;
    end
  endtask

  function automatic logic [32:0] pack(input int c, input logic [W-1:0] s, input logic [W-1:0] d);
    return {16'(c), s, |d, d};
  endfunction

  always @(posedge clk) begin
    model_step(0, 0, 63);
    model_step(1, 3, 65535);
    exp_q0.push_back(pack(m_cnt[0], m_sticky[0], m_dout[0]));
    exp_q3.push_back(pack(m_cnt[1], m_sticky[1], m_dout[1]));
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    logic [32:0] a;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = {10'b0, ev0, sticky0, any0, dout0};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_u0 @%0t: got cnt=%0d sticky=%h any=%b dout=%h, expected cnt=%0d sticky=%h any=%b dout=%h",
                 $time, a[32:17], a[16:9], a[8], a[7:0], e[32:17], e[16:9], e[8], e[7:0]);
      end
    end
    if (exp_q3.size() > 0) begin
      e = exp_q3.pop_front();
      a = {ev3, sticky3, any3, dout3};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_u3 @%0t: got cnt=%0d sticky=%h any=%b dout=%h, expected cnt=%0d sticky=%h any=%b dout=%h",
                 $time, a[32:17], a[16:9], a[8], a[7:0], e[32:17], e[16:9], e[8], e[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs, let one rising edge sample them, return 2 time units later.
  task automatic cyc(input logic [W-1:0] d, input logic [1:0] m, input logic c, input logic r);
    din   = d;
    mode  = m;
    clr   = c;
    reset = r;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    // Reset
    cyc(8'h00, RISE, 1'b0, 1'b1);
    cyc(8'h00, RISE, 1'b1, 1'b1);
    chk("reset_dout0", 32'(dout0), 32'h0);
    chk("reset_ev0", 32'(ev0), 32'h0);
    chk("reset_sticky3", 32'(sticky3), 32'h0);
    cyc(8'h00, RISE, 1'b0, 1'b0);
    cyc(8'h00, RISE, 1'b0, 1'b0);

    // Single rising edge, FILT=0, mode=rise
    cyc(8'h01, RISE, 1'b0, 1'b0);
    chk("rise_pulse_u0", 32'(dout0), 32'h01);
    chk("rise_any_u0", 32'(any0), 32'h1);
    cyc(8'h01, RISE, 1'b0, 1'b0);
    chk("rise_pulse_end_u0", 32'(dout0), 32'h00);
    chk("rise_cnt_u0", 32'(ev0), 32'd1);
    chk("rise_sticky_u0", 32'(sticky0), 32'h01);
    cyc(8'h01, RISE, 1'b0, 1'b0);
    chk("filt3_not_yet", 32'(dout3), 32'h00);
    cyc(8'h01, RISE, 1'b0, 1'b0);
    chk("filt3_latency", 32'(dout3), 32'h01);
    cyc(8'h01, RISE, 1'b0, 1'b0);
    cyc(8'h01, RISE, 1'b1, 1'b0);
    chk("clr_sticky_u0", 32'(sticky0), 32'h00);
    chk("clr_cnt_u0", 32'(ev0), 32'h0);

    // Glitch of 3 samples then a real 4-sample level on bit 2, mode=both
    for (int i = 0; i < 3; i++) cyc(8'h05, BOTH, 1'b0, 1'b0);
    cyc(8'h01, BOTH, 1'b0, 1'b0);
    cyc(8'h01, BOTH, 1'b0, 1'b0);
    chk("glitch_sticky_u3", 32'(sticky3), 32'h00);
    for (int i = 0; i < 3; i++) cyc(8'h05, BOTH, 1'b0, 1'b0);
    chk("filt3_hold_early", 32'(dout3), 32'h00);
    cyc(8'h05, BOTH, 1'b0, 1'b0);
    chk("filt3_hold_pulse", 32'(dout3), 32'h04);
    cyc(8'h05, BOTH, 1'b0, 1'b0);
    chk("filt3_hold_end", 32'(dout3), 32'h00);
    chk("filt3_sticky", 32'(sticky3), 32'h04);

    // Back-to-back toggling, FILT=0, mode=both
    cyc(8'h00, BOTH, 1'b0, 1'b0);
    cyc(8'h00, BOTH, 1'b0, 1'b0);
    cyc(8'h00, BOTH, 1'b1, 1'b0);
    chk("b2b_clr_cnt", 32'(ev0), 32'h0);
    cyc(8'hFF, BOTH, 1'b0, 1'b0);
    chk("b2b_1", 32'(dout0), 32'hFF);
    cyc(8'h00, BOTH, 1'b0, 1'b0);
    chk("b2b_2", 32'(dout0), 32'hFF);
    cyc(8'hFF, BOTH, 1'b0, 1'b0);
    chk("b2b_3", 32'(dout0), 32'hFF);
    cyc(8'hFF, BOTH, 1'b0, 1'b0);
    chk("b2b_quiet", 32'(dout0), 32'h00);
    chk("b2b_cnt24", 32'(ev0), 32'd24);

    // Saturation of the 6-bit counter, then clr on a 2-channel pulse
    for (int i = 0; i < 10; i++) cyc((i % 2 == 0) ? 8'h00 : 8'hFF, BOTH, 1'b0, 1'b0);
    cyc(8'hFF, BOTH, 1'b0, 1'b0);
    chk("sat_cnt_u0", 32'(ev0), 32'd63);
    chk("sat_model", 32'(m_cnt[0]), 32'd63);
    cyc(8'hFC, BOTH, 1'b0, 1'b0);
    chk("two_pulse", 32'(dout0), 32'h03);
    cyc(8'hFC, BOTH, 1'b1, 1'b0);
    chk("clr_on_pulse_cnt", 32'(ev0), 32'd2);
    chk("clr_on_pulse_sticky", 32'(sticky0), 32'h03);

    // mode=off: level tracks silently, then fall edge with mode=fall
    cyc(8'h0F, OFF, 1'b0, 1'b0);
    cyc(8'hF0, OFF, 1'b0, 1'b0);
    cyc(8'h0F, OFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(8'hF0, OFF, 1'b0, 1'b0);
    cyc(8'hF0, OFF, 1'b1, 1'b0);
    chk("off_sticky_u0", 32'(sticky0), 32'h00);
    chk("off_sticky_u3", 32'(sticky3), 32'h00);
    chk("off_cnt_u3", 32'(ev3), 32'h0);
    cyc(8'h00, FALL, 1'b0, 1'b0);
    chk("fall_pulse_u0", 32'(dout0), 32'hF0);
    cyc(8'h00, FALL, 1'b0, 1'b0);
    cyc(8'h00, FALL, 1'b0, 1'b0);
    chk("fall_early_u3", 32'(dout3), 32'h00);
    cyc(8'h00, FALL, 1'b0, 1'b0);
    chk("fall_pulse_u3", 32'(dout3), 32'hF0);

    // Reset mid-filter with din=0F, then release
    cyc(8'h0F, BOTH, 1'b0, 1'b0);
    cyc(8'h0F, BOTH, 1'b0, 1'b0);
    cyc(8'h0F, BOTH, 1'b1, 1'b1);
    chk("rst_dout0", 32'(dout0), 32'h00);
    chk("rst_dout3", 32'(dout3), 32'h00);
    chk("rst_sticky0", 32'(sticky0), 32'h00);
    chk("rst_cnt3", 32'(ev3), 32'h0);
    chk("rst_any0", 32'(any0), 32'h0);
    cyc(8'h0F, BOTH, 1'b0, 1'b0);
    chk("rel_pulse_u0", 32'(dout0), 32'h0F);
    cyc(8'h0F, BOTH, 1'b0, 1'b0);
    chk("rel_quiet_u0", 32'(dout0), 32'h00);
    cyc(8'h0F, BOTH, 1'b0, 1'b0);
    chk("rel_early_u3", 32'(dout3), 32'h00);
    cyc(8'h0F, BOTH, 1'b0, 1'b0);
    chk("rel_pulse_u3", 32'(dout3), 32'h0F);
    cyc(8'h0F, BOTH, 1'b0, 1'b0);
    chk("rel_cnt_u3", 32'(ev3), 32'd4);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/edge_detector_mc.md
EDGE_DETECTOR_MC -- requirements
Module: edge_detector_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent input channels (1..32).
REQ-002 SHALL have parameter FILT, default 0: extra consecutive samples a new level must hold before it is accepted (0..255).
REQ-003 SHALL have parameter CNT_W, default 16: width of the saturating event counter (>= 6).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port din, input, WIDTH: asynchronous-free channel inputs, sampled on clk.
REQ-007 SHALL have port mode, input, 2: edge select, where 00 is rise, 01 is fall, 10 is both and 11 is disabled.
REQ-008 SHALL have port clr, input, 1: clears sticky and event_cnt.
REQ-009 SHALL have port dout, output, WIDTH: a one-cycle pulse per accepted edge matching mode.
REQ-010 SHALL have port sticky, output, WIDTH: a per-channel latched flag that an edge pulse occurred since the last clr or reset.
REQ-011 SHALL have port any_edge, output, 1: the OR of dout.
REQ-012 SHALL have port event_cnt, output, CNT_W: the saturating total of dout pulses.

Function
REQ-013 Each channel SHALL hold a filtered level lvl[i] and a stability counter cnt[i] of width clog2(FILT+1), minimum 1.
REQ-014 On each clk edge, if din[i]==lvl[i], the channel SHALL set cnt[i] to 0.
REQ-015 Otherwise, if cnt[i]==FILT, the channel SHALL set lvl[i] to din[i] and cnt[i] to 0, and the change SHALL be an accepted edge.
REQ-016 Otherwise the channel SHALL increment cnt[i]; a glitch shorter than FILT+1 samples SHALL produce no edge and SHALL reset cnt[i].
REQ-017 An accepted edge SHALL be rising if the new lvl is 1 and falling if it is 0.
REQ-018 On the same clk edge that accepts it, an edge SHALL drive dout[i] to 1 if mode selects that direction; dout[i] SHALL be 0 in all other cycles.
REQ-019 Latency SHALL be as follows: with din[i] first sampled at its new level on edge k, dout[i] SHALL be high from edge k+FILT to edge k+FILT+1; FILT=0 therefore gives a single-cycle registered pulse.
REQ-020 Back-to-back toggling with FILT=0 and mode=both SHALL produce dout[i] high on every cycle.
REQ-021 lvl SHALL track din regardless of mode; mode=11 SHALL suppress pulses only, with no filter side effects.
REQ-022 A mode change SHALL apply to edges accepted on or after the edge where the new mode is sampled and SHALL NOT act retroactively.
REQ-023 sticky[i] SHALL be set by dout[i] and SHALL hold until clr or reset.
REQ-024 event_cnt SHALL add popcount(dout) on the edge following each pulse cycle and SHALL saturate at 2^CNT_W-1, never wrapping.
REQ-025 When clr is sampled high, sticky SHALL be set to dout and event_cnt SHALL be set to popcount(dout), so that an event coinciding with clr is not lost.
REQ-026 any_edge SHALL be combinational OR of dout, with no extra latency.

Reset
REQ-027 While reset is high at clk, the block SHALL force lvl=0, cnt=0, dout=0, sticky=0 and event_cnt=0.
REQ-028 Reset SHALL take priority over clr, din and mode.
REQ-029 Reset asserted mid-filter SHALL discard the pending count.
REQ-030 Because lvl resets to 0, a din channel held at 1 through reset release SHALL yield a rising edge FILT+1 samples after release.

Structure
REQ-031 Package edge_pkg SHALL hold typedef enum logic[1:0] edge_mode_t (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF) and the popcount function.
REQ-032 Sub-module edge_chan SHALL contain one channel's lvl, cnt and dout logic with parameter FILT.
REQ-033 The top level SHALL instantiate edge_chan WIDTH times and own sticky, event_cnt and any_edge.

Verification
REQ-034 Scenario, FILT=0, WIDTH=8, mode=rise: din[0] 0->1 before edge 5 -> dout[0]=1 during cycle 5 only, event_cnt=1, sticky=8'h01.
REQ-035 Scenario, FILT=3, mode=both: din[2] high for 3 samples then low -> no pulse; high for 4 samples -> one dout[2] pulse 3 cycles after the first high sample.
REQ-036 Scenario, FILT=0, mode=both: din=8'hFF then 8'h00 then 8'hFF on consecutive cycles -> dout=8'hFF for 3 cycles, event_cnt=24.
REQ-037 Scenario, CNT_W=6: force 70 pulses -> event_cnt stops at 63; clr coincident with a 2-channel pulse -> event_cnt=2.
REQ-038 Scenario, mode=off: toggling din -> no dout pulses, lvl still tracks; switch to fall with din then falling -> pulse.
REQ-039 Scenario: reset asserted while din=8'h0F and cnt is mid-count -> all outputs 0 next cycle; after release with FILT=0, dout=8'h0F one cycle.
